// File: rtl/frame_border_pad.sv
// frame_border_pad: streams one WIDTHxHEIGHT frame and re-emits it padded by (KERNEL-1)/2
// pixels per side, using zero fill or edge replication, with an optional idle gap after each row.
`default_nettype none
module frame_border_pad #(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int KERNEL   = 7,
  parameter int CHANNELS = 3,
  parameter int DW       = 8,
  parameter int MODE     = 0,
  parameter int ROW_GAP  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   newFrame,
  input  logic                   iValid,
  output logic                   iReady,
  input  logic [CHANNELS*DW-1:0] iData,
  output logic                   oValid,
  output logic [CHANNELS*DW-1:0] oData,
  output logic                   oSOF,
  output logic                   oEOL,
  output logic                   oDone
);
  localparam int B   = (KERNEL - 1) / 2;
  localparam int PW  = WIDTH + 2 * B;
  localparam int PH  = HEIGHT + 2 * B;
  localparam int PXW = CHANNELS * DW;
  localparam int CW  = $clog2(PW);
  localparam int RW  = $clog2(PH);
  localparam int GW  = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;
  localparam int AW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(PW - 1);
  localparam logic [CW-1:0] COL_BODY  = CW'(B);
  localparam logic [CW-1:0] COL_RPAD  = CW'(WIDTH + B);
  localparam logic [CW-1:0] CAP_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(PH - 1);
  localparam logic [RW-1:0] ROW_BODY  = RW'(B);
  localparam logic [RW-1:0] ROW_LIVE  = RW'(B + 1);
  localparam logic [RW-1:0] ROW_BPAD  = RW'(HEIGHT + B);
  localparam logic [AW-1:0] ADDR_LAST = AW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_ROW     = 3'd2,
    S_GAP     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            oValid_q, oValid_d;
  logic [PXW-1:0]  oData_q, oData_d;
  logic            oSOF_q, oSOF_d;
  logic            oEOL_q, oEOL_d;
  logic            oDone_q, oDone_d;

  logic [PXW-1:0]  lbuf_q [WIDTH];
  logic            buf_we;
  logic [AW-1:0]   buf_waddr;
  logic [AW-1:0]   buf_raddr;
  logic [PXW-1:0]  buf_rdata;

  logic            col_lpad, col_rpad, row_tpad, row_bpad, row_live;
  logic            emit;
  logic [PXW-1:0]  pix;

  assign col_lpad  = (col_q < COL_BODY);
  assign col_rpad  = (col_q >= COL_RPAD);
  assign row_tpad  = (row_q < ROW_BODY);
  assign row_bpad  = (row_q >= ROW_BPAD);
  assign row_live  = (row_q >= ROW_LIVE) && !row_bpad;
  // Column clamp into the line buffer; pad columns read the nearest edge pixel.
  assign buf_raddr = col_lpad ? '0 : (col_rpad ? ADDR_LAST : AW'(col_q - COL_BODY));
  assign buf_rdata = lbuf_q[buf_raddr];

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    gap_d     = gap_q;
    iReady    = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = AW'(col_q - COL_BODY);
    emit      = 1'b0;
    pix       = '0;
    oValid_d  = 1'b0;
    oData_d   = '0;
    oSOF_d    = 1'b0;
    oEOL_d    = 1'b0;
    oDone_d   = 1'b0;

    unique case (state_q)
      S_CAPTURE: begin
        iReady    = 1'b1;
        buf_waddr = AW'(col_q);
        if (iValid) begin
          buf_we = 1'b1;
          if (col_q == CAP_LAST) begin
            col_d   = '0;
            state_d = S_ROW;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_ROW: begin
        emit = 1'b1;
        if (MODE == 0) begin
          if (!row_tpad && !row_bpad && !col_lpad && !col_rpad) begin
            iReady = 1'b1;
            emit   = iValid;
            pix    = iData;
          end
        end else if (row_live && !col_rpad) begin
          // Left pad only peeks the first pixel of the row; the body consumes it.
          emit = iValid;
          pix  = iData;
          if (!col_lpad) begin
            iReady = 1'b1;
            buf_we = iValid;
          end
        end else begin
          pix = buf_rdata;
        end
        if (emit) begin
          oValid_d = 1'b1;
          oData_d  = pix;
          oSOF_d   = (row_q == '0) && (col_q == '0);
          oEOL_d   = (col_q == COL_LAST);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (ROW_GAP > 0) begin
              state_d = S_GAP;
            end else if (row_q == ROW_LAST) begin
              state_d = S_DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_ROW;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        oDone_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
      end
    endcase

    // A new frame overrides everything except a completing frame's oDone.
    if (newFrame) begin
      state_d  = (MODE == 0) ? S_ROW : S_CAPTURE;
      col_d    = '0;
      row_d    = '0;
      gap_d    = '0;
      iReady   = 1'b0;
      buf_we   = 1'b0;
      oValid_d = 1'b0;
      oData_d  = '0;
      oSOF_d   = 1'b0;
      oEOL_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      gap_q    <= '0;
      oValid_q <= 1'b0;
      oData_q  <= '0;
      oSOF_q   <= 1'b0;
      oEOL_q   <= 1'b0;
      oDone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      gap_q    <= gap_d;
      oValid_q <= oValid_d;
      oData_q  <= oData_d;
      oSOF_q   <= oSOF_d;
      oEOL_q   <= oEOL_d;
      oDone_q  <= oDone_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      lbuf_q[buf_waddr] <= iData;
    end
  end

  assign oValid = oValid_q;
  assign oData  = oData_q;
  assign oSOF   = oSOF_q;
  assign oEOL   = oEOL_q;
  assign oDone  = oDone_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_border_pad.sv
// tb_frame_border_pad: drives a zero-pad instance and a replicate instance with random
// streams and compares every padded pixel against a coordinate-based clamp/zero model.
`default_nettype none
`timescale 1ns/1ps
module tb_frame_border_pad;
  localparam int ZW = 4, ZH = 3, ZK = 3, ZG = 2;
  localparam int ZB = (ZK - 1) / 2, ZPW = ZW + 2 * ZB, ZPH = ZH + 2 * ZB;
  localparam int RWID = 5, RH = 4, RK = 5, RG = 0;
  localparam int RB = (RK - 1) / 2, RPW = RWID + 2 * RB, RPH = RH + 2 * RB;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        z_nf, z_iv, z_ir, z_ov, z_sof, z_eol, z_done;
  logic [7:0]  z_id, z_od;
  logic        r_nf, r_iv, r_ir, r_ov, r_sof, r_eol, r_done;
  logic [15:0] r_id, r_od;

  frame_border_pad #(.WIDTH(ZW), .HEIGHT(ZH), .KERNEL(ZK), .CHANNELS(1), .DW(8),
                     .MODE(0), .ROW_GAP(ZG)) u_zero (
    .clk(clk), .reset(reset), .newFrame(z_nf), .iValid(z_iv), .iReady(z_ir), .iData(z_id),
    .oValid(z_ov), .oData(z_od), .oSOF(z_sof), .oEOL(z_eol), .oDone(z_done));

  frame_border_pad #(.WIDTH(RWID), .HEIGHT(RH), .KERNEL(RK), .CHANNELS(2), .DW(8),
                     .MODE(1), .ROW_GAP(RG)) u_repl (
    .clk(clk), .reset(reset), .newFrame(r_nf), .iValid(r_iv), .iReady(r_ir), .iData(r_id),
    .oValid(r_ov), .oData(r_od), .oSOF(r_sof), .oEOL(r_eol), .oDone(r_done));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  zpix [ZW*ZH];
  logic [15:0] rpix [RWID*RH];
  logic [31:0] z_q[$];
  logic [31:0] r_q[$];
  bit z_mon = 0, r_mon = 0;
  int z_cyc, z_eol_cyc, z_done_n;
  int r_cyc, r_eol_cyc, r_done_n;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Expected stream: {eol, sof, data} for every padded coordinate in raster order.
  task automatic z_model();
    z_q.delete();
    for (int r = 0; r < ZPH; r++) begin
      for (int c = 0; c < ZPW; c++) begin
        logic [31:0] e;
        int ir, ic;
        ir = r - ZB;
        ic = c - ZB;
        e = '0;
        if (ir >= 0 && ir < ZH && ic >= 0 && ic < ZW) e[7:0] = zpix[ir*ZW+ic];
        e[8] = (r == 0 && c == 0);
        e[9] = (c == ZPW - 1);
        z_q.push_back(e);
      end
    end
  endtask

  task automatic r_model();
    r_q.delete();
    for (int r = 0; r < RPH; r++) begin
      for (int c = 0; c < RPW; c++) begin
        logic [31:0] e;
        e = '0;
        e[15:0] = rpix[clampi(r - RB, 0, RH - 1)*RWID + clampi(c - RB, 0, RWID - 1)];
        e[16] = (r == 0 && c == 0);
        e[17] = (c == RPW - 1);
        r_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (z_mon) begin
      z_cyc++;
      if (z_ov) begin
        chk("z_underflow", z_q.size() > 0, 1);
        if (z_q.size() > 0) chk("z_pix", {z_eol, z_sof, z_od}, z_q.pop_front());
        if (z_eol_cyc >= 0) chk("z_row_gap", z_cyc - z_eol_cyc - 1, ZG);
        z_eol_cyc = z_eol ? z_cyc : -1;
      end
      if (z_done) begin
        z_done_n++;
        chk("z_done_gap", z_cyc - z_eol_cyc - 1, ZG);
        chk("z_done_early", z_q.size(), 0);
      end
    end
    if (r_mon) begin
      r_cyc++;
      if (r_ov) begin
        chk("r_underflow", r_q.size() > 0, 1);
        if (r_q.size() > 0) chk("r_pix", {r_eol, r_sof, r_od}, r_q.pop_front());
        r_eol_cyc = r_eol ? r_cyc : -1;
      end
      if (r_done) begin
        r_done_n++;
        chk("r_done_gap", r_cyc - r_eol_cyc - 1, RG);
        chk("r_done_early", r_q.size(), 0);
      end
    end
  end

  task automatic z_feed(input int n, input int vpct);
    int idx, budget;
    bit xfer;
    idx = 0;
    budget = 0;
    while (idx < n && budget < 1000) begin
      z_iv = ($urandom_range(99) < vpct);
      z_id = zpix[idx];
      @(negedge clk);
      xfer = z_iv && z_ir;
      @(posedge clk); #1;
      if (xfer) idx++;
      budget++;
    end
    z_iv = 1'b0;
    chk("z_feed_budget", idx, n);
  endtask

  task automatic r_feed(input int n, input int vpct);
    int idx, budget;
    bit xfer;
    idx = 0;
    budget = 0;
    while (idx < n && budget < 1000) begin
      r_iv = ($urandom_range(99) < vpct);
      r_id = rpix[idx];
      @(negedge clk);
      xfer = r_iv && r_ir;
      @(posedge clk); #1;
      if (xfer) idx++;
      budget++;
    end
    r_iv = 1'b0;
    chk("r_feed_budget", idx, n);
  endtask

  task automatic z_frame(input int vpct, input int abort_n, input bit ramp);
    int budget;
    for (int i = 0; i < ZW*ZH; i++) zpix[i] = ramp ? 8'(i + 1) : 8'($urandom);
    if (abort_n > 0) begin
      z_mon = 0;
      z_nf = 1'b1; @(posedge clk); #1; z_nf = 1'b0;
      z_feed(abort_n, 100);
      repeat (3) @(posedge clk);
      #1;
    end
    z_model();
    z_cyc = 0; z_eol_cyc = -1; z_done_n = 0;
    z_nf = 1'b1; @(posedge clk); #1; z_nf = 1'b0;
    z_mon = 1;
    z_feed(ZW*ZH, vpct);
    budget = 0;
    while (z_done_n == 0 && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("z_done_count", z_done_n, 1);
    chk("z_leftover", z_q.size(), 0);
    z_mon = 0;
    z_iv = 1'b1;
    @(negedge clk);
    chk("z_idle_ready", z_ir, 0);
    @(posedge clk); #1;
    z_iv = 1'b0;
  endtask

  task automatic r_frame(input int vpct, input int abort_n, input bit ramp);
    int budget;
    for (int i = 0; i < RWID*RH; i++) rpix[i] = ramp ? 16'(i + 1) : 16'($urandom);
    if (abort_n > 0) begin
      r_mon = 0;
      r_nf = 1'b1; @(posedge clk); #1; r_nf = 1'b0;
      r_feed(abort_n, 100);
      repeat (3) @(posedge clk);
      #1;
    end
    r_model();
    r_cyc = 0; r_eol_cyc = -1; r_done_n = 0;
    r_nf = 1'b1; @(posedge clk); #1; r_nf = 1'b0;
    r_mon = 1;
    r_feed(RWID*RH, vpct);
    budget = 0;
    while (r_done_n == 0 && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("r_done_count", r_done_n, 1);
    chk("r_leftover", r_q.size(), 0);
    r_mon = 0;
  endtask

  initial begin
    reset = 1'b0;
    z_nf = 0; z_iv = 0; z_id = '0;
    r_nf = 0; r_iv = 0; r_id = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_zero_out", {z_ov, z_sof, z_eol, z_done, z_ir, z_od}, 0);
    chk("rst_repl_out", {r_ov, r_sof, r_eol, r_done, r_ir, r_od}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    z_frame(100, 0, 1'b1);
    z_frame(50, 0, 1'b1);
    z_frame(70, 0, 1'b0);
    z_frame(100, 5, 1'b1);

    r_frame(100, 0, 1'b1);
    r_frame(50, 0, 1'b0);
    r_frame(80, 7, 1'b0);

    // Reset in the middle of a replicate frame, then a clean frame.
    r_mon = 0;
    for (int i = 0; i < RWID*RH; i++) rpix[i] = 16'($urandom);
    r_nf = 1'b1; @(posedge clk); #1; r_nf = 1'b0;
    r_feed(8, 100);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_mid_out", {r_ov, r_sof, r_eol, r_done, r_ir, r_od}, 0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    r_iv = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_after_quiet", {r_ov, r_done, r_ir}, 0);
      @(posedge clk); #1;
    end
    r_iv = 1'b0;
    r_frame(100, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_checks, 0);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
